// File: rtl/philv_fetch_pkg.sv
// Shared types and constants for the fetch front end.
package philv_fetch_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Derived status of the fetch stage, used for debug and assertions.
    typedef enum logic [1:0] {
        FETCH,
        STALL,
        DRAIN
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with synchronous flush. The head entry is read
// straight from storage; a word pushed this cycle is visible next cycle.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers simply wrap.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage write; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited requests to
// instruction memory, buffers tagged responses for decode, and handles
// redirects by flushing the buffer and discarding in-flight responses.
// XLEN must match the package XLEN since buffered entries use fetch_entry_t.
module instr_fetch_unit #(
    parameter int              XLEN     = philv_fetch_pkg::XLEN,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = philv_fetch_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc_cur,
    input  logic [XLEN-1:0] pc_next,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            dec_valid,
    output logic [XLEN-1:0] dec_pc,
    output logic [31:0]     dec_instr,
    input  logic            dec_ready
);

    import philv_fetch_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc_q;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   ibuf_count;
    logic [CW-1:0]   tag_count;
    logic            credit_ok;
    logic            grant;
    logic            resp;
    logic            keep;
    logic            dec_pop;
    logic [XLEN-1:0] tag_head;
    logic            tag_empty;
    logic            tag_full;
    logic            ibuf_empty;
    logic            ibuf_full;
    fetch_entry_t    ibuf_in;
    fetch_entry_t    ibuf_head;
    fetch_state_e    state;

    // Requests in flight plus instructions already buffered may never
    // exceed DEPTH, which is what keeps both FIFOs from overflowing.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, ibuf_count}) < (CW + 1)'(DEPTH);
    assign imem_req  = !rst && !redirect_valid && credit_ok;
    assign imem_addr = pc_q;
    assign pc_cur    = pc_q;
    assign grant     = imem_req && imem_gnt;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp      = imem_rvalid && (outstanding != '0);
    assign keep      = resp && (discard == '0) && !redirect_valid;

    assign dec_valid = !rst && !ibuf_empty;
    assign dec_pop   = dec_valid && dec_ready && !redirect_valid;
    assign dec_pc    = ibuf_head.pc;
    assign dec_instr = ibuf_head.instr;

    assign ibuf_in.pc    = tag_head;
    assign ibuf_in.instr = imem_rdata;

    // Tags follow requests in order and are never flushed, so stale tags
    // leave together with their discarded responses.
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (grant),
        .push_data (pc_q),
        .pop       (resp),
        .pop_data  (tag_head),
        .empty     (tag_empty),
        .full      (tag_full),
        .count     (tag_count)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_ibuf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (keep),
        .push_data (ibuf_in),
        .pop       (dec_pop),
        .pop_data  (ibuf_head),
        .empty     (ibuf_empty),
        .full      (ibuf_full),
        .count     (ibuf_count)
    );

    // Fetch PC: redirect beats a grant; a grant advances to the sequential successor.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc;
        end else if (grant) begin
            pc_q <= pc_next;
        end
    end

    // In-flight and discard counters; a redirect marks every response still
    // owed after this cycle as stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(resp);
            if (redirect_valid) begin
                discard <= outstanding - CW'(resp);
            end else if (resp && (discard != '0)) begin
                discard <= discard - CW'(1);
            end
        end
    end

    // Status classification: draining stale responses dominates a credit stall.
    always_comb begin
        state = FETCH;
        if (discard != '0) begin
            state = DRAIN;
        end else if (!credit_ok) begin
            state = STALL;
        end
    end

    // Structural invariants and the memory protocol rule.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_rvalid && (outstanding == '0)));
            assert (({1'b0, outstanding} + {1'b0, ibuf_count}) <= (CW + 1)'(DEPTH));
            assert (tag_count == outstanding);
            assert (discard <= outstanding);
            assert (!(grant && tag_full));
            assert (!(keep && ibuf_full));
            assert (!(resp && tag_empty));
            assert (!((state == STALL) && imem_req));
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table plus randomized traffic
// against a queue-based model of the fetch/decode stream.
module tb_instr_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic        dec_ready = 1'b0;

    int n_checks  = 0;
    int n_fail    = 0;
    int n_decoded = 0;

    // Memory: addresses granted, answered in order.
    logic [31:0] mem_q[$];

    // Model: next fetch PC, PCs in flight, PCs buffered for decode.
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] out_q[$];
    logic [31:0] buf_q[$];
    int          discard = 0;
    logic        model_ok = 1'b0;
    logic        exp_req;
    logic        exp_dv;

    typedef struct {
        logic        rst;
        logic        gnt;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        rv;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic        e_dv;
        logic [31:0] e_dpc;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    // The program counter block: sequential successor of the fetch PC.
    assign pc_next = pc_cur + 32'd4;

    instr_fetch_unit #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_cur         (pc_cur),
        .pc_next        (pc_next),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .dec_valid      (dec_valid),
        .dec_pc         (dec_pc),
        .dec_instr      (dec_instr),
        .dec_ready      (dec_ready)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[24:0], 7'h13};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic g, input logic d, input logic rd,
                                 input logic [31:0] rp, input logic rv_en);
        @(negedge clk);
        rst            = r;
        imem_gnt       = g;
        dec_ready      = d;
        redirect_valid = rd;
        redirect_pc    = rp;
        imem_rvalid    = rv_en && (mem_q.size() > 0);
        imem_rdata     = imem_rvalid ? instr_of(mem_q[0]) : 32'hDEAD_BEEF;
        #1;
    endtask

    task automatic modelCheck();
        exp_req = !rst && !redirect_valid && ((out_q.size() + buf_q.size()) < DEPTH);
        exp_dv  = !rst && (buf_q.size() > 0);
        checkOutput("m_imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        checkOutput("m_dec_valid", {31'b0, dec_valid}, {31'b0, exp_dv});
        if (model_ok) begin
            checkOutput("m_pc_cur", pc_cur, exp_pc);
        end
        if (exp_req) begin
            checkOutput("m_imem_addr", imem_addr, exp_pc);
        end
        if (exp_dv) begin
            checkOutput("m_dec_pc", dec_pc, buf_q[0]);
            checkOutput("m_dec_instr", dec_instr, instr_of(buf_q[0]));
        end
    endtask

    task automatic stepModel();
        logic [31:0] a;
        if (rst) begin
            mem_q.delete();
        end else begin
            if (imem_rvalid) void'(mem_q.pop_front());
            if (imem_req && imem_gnt) mem_q.push_back(imem_addr);
        end
        if (rst) begin
            out_q.delete();
            buf_q.delete();
            discard  = 0;
            exp_pc   = RESET_PC;
            model_ok = 1'b1;
        end else if (redirect_valid) begin
            discard = out_q.size() - ((imem_rvalid && out_q.size() > 0) ? 1 : 0);
            if (imem_rvalid && out_q.size() > 0) void'(out_q.pop_front());
            buf_q.delete();
            exp_pc = redirect_pc;
        end else begin
            if (exp_dv && dec_ready && buf_q.size() > 0) begin
                void'(buf_q.pop_front());
                n_decoded++;
            end
            if (imem_rvalid && out_q.size() > 0) begin
                a = out_q.pop_front();
                if (discard > 0) discard--;
                else buf_q.push_back(a);
            end
            if (exp_req && imem_gnt) begin
                out_q.push_back(exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
        end
    endtask

    task automatic addVec(input logic r, input logic g, input logic d, input logic rd, input logic [31:0] rp,
                          input logic rv, input logic eq, input logic [31:0] ea, input logic [31:0] ep,
                          input logic ev, input logic [31:0] edp);
        vecs.push_back('{rst: r, gnt: g, rdy: d, redir: rd, rpc: rp, rv: rv,
                         e_req: eq, e_addr: ea, e_pc: ep, e_dv: ev, e_dpc: edp});
    endtask

    initial begin
        logic [31:0] rp;

        // Streaming with full credit use
        addVec(0,1,1,0,0,1, 1,32'h000,32'h000, 0,0);
        addVec(0,1,1,0,0,1, 1,32'h004,32'h004, 0,0);
        addVec(0,1,1,0,0,1, 0,0,      32'h008, 1,32'h000);
        addVec(0,1,1,0,0,1, 1,32'h008,32'h008, 1,32'h004);
        addVec(0,1,1,0,0,1, 1,32'h00C,32'h00C, 0,0);
        addVec(0,1,1,0,0,1, 0,0,      32'h010, 1,32'h008);
        // Decode back-pressure
        addVec(0,1,0,0,0,1, 1,32'h010,32'h010, 1,32'h00C);
        addVec(0,1,0,0,0,1, 0,0,      32'h014, 1,32'h00C);
        addVec(0,1,0,0,0,1, 0,0,      32'h014, 1,32'h00C);
        addVec(0,1,1,0,0,1, 0,0,      32'h014, 1,32'h00C);
        addVec(0,1,1,0,0,1, 1,32'h014,32'h014, 1,32'h010);
        // Memory withholds grant
        addVec(0,0,1,0,0,1, 1,32'h018,32'h018, 0,0);
        addVec(0,0,1,0,0,1, 1,32'h018,32'h018, 1,32'h014);
        addVec(0,0,1,0,0,1, 1,32'h018,32'h018, 0,0);
        addVec(0,1,1,0,0,1, 1,32'h018,32'h018, 0,0);
        addVec(0,1,1,0,0,1, 1,32'h01C,32'h01C, 0,0);
        // Two outstanding, then redirect to 0x100
        addVec(0,1,1,0,0,0, 0,0,      32'h020, 1,32'h018);
        addVec(0,1,1,0,0,0, 1,32'h020,32'h020, 0,0);
        addVec(0,1,1,1,32'h100,0, 0,0,32'h024, 0,0);
        addVec(0,1,1,0,0,1, 0,0,      32'h100, 0,0);
        addVec(0,1,1,0,0,1, 1,32'h100,32'h100, 0,0);
        addVec(0,1,1,0,0,1, 1,32'h104,32'h104, 0,0);
        addVec(0,1,1,0,0,1, 0,0,      32'h108, 1,32'h100);
        addVec(0,1,1,0,0,1, 1,32'h108,32'h108, 1,32'h104);
        // Redirect together with a response and a decode pop
        addVec(0,1,0,0,0,1, 1,32'h10C,32'h10C, 0,0);
        addVec(0,1,1,1,32'h200,1, 0,0,32'h110, 1,32'h108);
        addVec(0,1,1,0,0,1, 1,32'h200,32'h200, 0,0);
        addVec(0,1,1,0,0,1, 1,32'h204,32'h204, 0,0);
        addVec(0,1,1,0,0,1, 0,0,      32'h208, 1,32'h200);
        // Fill the buffer, then reset mid-stream
        addVec(0,1,0,0,0,1, 1,32'h208,32'h208, 1,32'h204);
        addVec(0,1,0,0,0,1, 0,0,      32'h20C, 1,32'h204);
        addVec(1,1,0,0,0,1, 0,0,      32'h20C, 0,0);
        addVec(0,1,1,0,0,1, 1,32'h000,32'h000, 0,0);
        addVec(0,1,1,0,0,1, 1,32'h004,32'h004, 0,0);

        // Reset sequence
        applyStimulus(1, 0, 0, 0, 0, 0);
        modelCheck();
        stepModel();
        applyStimulus(1, 1, 1, 0, 0, 0);
        checkOutput("rst_pc_cur", pc_cur, RESET_PC);
        checkOutput("rst_imem_req", {31'b0, imem_req}, 32'd0);
        checkOutput("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
        modelCheck();
        stepModel();

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].gnt, vecs[i].rdy, vecs[i].redir, vecs[i].rpc, vecs[i].rv);
            checkOutput($sformatf("v%0d_imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
            checkOutput($sformatf("v%0d_pc_cur", i), pc_cur, vecs[i].e_pc);
            checkOutput($sformatf("v%0d_dec_valid", i), {31'b0, dec_valid}, {31'b0, vecs[i].e_dv});
            if (vecs[i].e_req) begin
                checkOutput($sformatf("v%0d_imem_addr", i), imem_addr, vecs[i].e_addr);
            end
            if (vecs[i].e_dv) begin
                checkOutput($sformatf("v%0d_dec_pc", i), dec_pc, vecs[i].e_dpc);
                checkOutput($sformatf("v%0d_dec_instr", i), dec_instr, instr_of(vecs[i].e_dpc));
            end
            modelCheck();
            stepModel();
        end

        // Randomized traffic including redirects near the address wrap
        n_decoded = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rp = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
            end else begin
                rp = 32'($urandom_range(0, 1023)) << 2;
            end
            applyStimulus($urandom_range(0, 127) == 0,
                          $urandom_range(0, 9) < 7,
                          $urandom_range(0, 9) < 7,
                          $urandom_range(0, 15) == 0,
                          rp,
                          $urandom_range(0, 9) < 6);
            modelCheck();
            stepModel();
        end
        checkOutput("random_progress", {31'b0, (n_decoded > 200)}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
